// File: rtl/comparator_64bit_seq_ctrl_if.sv
// Handshake bus for the sequential magnitude comparator: operand request side and result side.
interface comparator_64bit_seq_ctrl_if #(
    parameter int unsigned WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic             greater;
    logic             less;
    logic             equal;
    logic [7:0]       cmp_cycles;

    // Producer/consumer side of the comparator.
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, greater, less, equal, cmp_cycles
    );

    // Comparator side.
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, greater, less, equal, cmp_cycles
    );
endinterface

// File: rtl/comparator_64bit_seq_ctrl.sv
// Sequential MSB-first magnitude comparator: one CHUNK-bit slice per clock, early exit on first difference.
// Define COMPARATOR_64BIT_SEQ_SIGNED_EN to treat operands as two's complement.
module comparator_64bit_seq_ctrl #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    comparator_64bit_seq_ctrl_if.slave        bus
);
    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic [7:0]         cnt_q;
    logic [7:0]         cnt_d;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               greater_q;
    logic               less_q;
    logic               equal_q;
    logic [7:0]         cmp_cycles_q;

    logic [CHUNK-1:0]   a_sl_c;
    logic [CHUNK-1:0]   b_sl_c;
    logic               sl_gt_c;
    logic               sl_lt_c;

    assign cnt_d = cnt_q + 8'd1;

    // Shared slice selector feeding the single narrow comparator.
    always_comb begin
        a_sl_c = '0;
        b_sl_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_sl_c = a_q[i*CHUNK +: CHUNK];
                b_sl_c = b_q[i*CHUNK +: CHUNK];
            end
        end
`ifdef COMPARATOR_64BIT_SEQ_SIGNED_EN
        // Flipping both sign bits turns the top-slice unsigned compare into a signed one.
        if (idx_q == IDX_W'(N-1)) begin
            a_sl_c[CHUNK-1] = ~a_sl_c[CHUNK-1];
            b_sl_c[CHUNK-1] = ~b_sl_c[CHUNK-1];
        end
`endif
    end

    assign sl_gt_c = (a_sl_c > b_sl_c);
    assign sl_lt_c = (a_sl_c < b_sl_c);

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            greater_q    <= 1'b0;
            less_q       <= 1'b0;
            equal_q      <= 1'b0;
            cmp_cycles_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        idx_q      <= IDX_W'(N-1);
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= CMP;
                    end
                end
                CMP: begin
                    cnt_q <= cnt_d;
                    if (sl_gt_c) begin
                        greater_q    <= 1'b1;
                        less_q       <= 1'b0;
                        equal_q      <= 1'b0;
                        cmp_cycles_q <= cnt_d;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end else if (sl_lt_c) begin
                        greater_q    <= 1'b0;
                        less_q       <= 1'b1;
                        equal_q      <= 1'b0;
                        cmp_cycles_q <= cnt_d;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end else if (idx_q == '0) begin
                        greater_q    <= 1'b0;
                        less_q       <= 1'b0;
                        equal_q      <= 1'b1;
                        cmp_cycles_q <= cnt_d;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.greater    = greater_q;
    assign bus.less       = less_q;
    assign bus.equal      = equal_q;
    assign bus.cmp_cycles = cmp_cycles_q;
endmodule

// File: tb/tb_comparator_64bit_seq_ctrl.sv
// Directed bench for comparator_64bit_seq_ctrl: hand-computed result, latency and handshake checks.
module tb_comparator_64bit_seq_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    comparator_64bit_seq_ctrl_if #(.WIDTH(64)) ifc ();

    comparator_64bit_seq_ctrl #(.WIDTH(64), .CHUNK(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction: accept, measure latency, check result, optional stall, release.
    task automatic run_cmp(input string tag, input logic [63:0] av, input logic [63:0] bv,
                           input logic eg, input logic el, input logic ee,
                           input int k, input int stall);
        int cyc;
        check({tag, "_in_ready_idle"}, 64'(ifc.in_ready), 64'd1);
        ifc.a        = av;
        ifc.b        = bv;
        ifc.in_valid = 1'b1;
        ifc.out_ready = 1'b0;
        tick();
        // Garbage on the bus and in_valid held high must not disturb the compare.
        ifc.a = {$urandom, $urandom};
        ifc.b = {$urandom, $urandom};
        cyc = 0;
        while (ifc.out_valid !== 1'b1 && cyc < 20) begin
            tick();
            cyc++;
        end
        ifc.in_valid = 1'b0;
        if (cyc >= 20) check({tag, "_timeout"}, 64'd0, 64'd1);
        check({tag, "_latency"}, 64'(cyc), 64'(k));
        check({tag, "_greater"}, 64'(ifc.greater), 64'(eg));
        check({tag, "_less"}, 64'(ifc.less), 64'(el));
        check({tag, "_equal"}, 64'(ifc.equal), 64'(ee));
        check({tag, "_cmp_cycles"}, 64'(ifc.cmp_cycles), 64'(k));
        check({tag, "_in_ready_busy"}, 64'(ifc.in_ready), 64'd0);
        for (int s = 0; s < stall; s++) begin
            tick();
            check({tag, "_stall_valid"}, 64'(ifc.out_valid), 64'd1);
            check({tag, "_stall_less"}, 64'(ifc.less), 64'(el));
            check({tag, "_stall_cycles"}, 64'(ifc.cmp_cycles), 64'(k));
            check({tag, "_stall_in_ready"}, 64'(ifc.in_ready), 64'd0);
        end
        ifc.out_ready = 1'b1;
        tick();
        ifc.out_ready = 1'b0;
        check({tag, "_valid_drop"}, 64'(ifc.out_valid), 64'd0);
        check({tag, "_in_ready_back"}, 64'(ifc.in_ready), 64'd1);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.a         = '0;
        ifc.b         = '0;
        ifc.out_ready = 1'b0;
        tick();
        tick();
        check("rst_in_ready", 64'(ifc.in_ready), 64'd1);
        check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("rst_flags", 64'({ifc.greater, ifc.less, ifc.equal}), 64'd0);
        check("rst_cmp_cycles", 64'(ifc.cmp_cycles), 64'd0);
        rst_n = 1'b1;
        tick();

        run_cmp("eq_zero", 64'h0, 64'h0, 1'b0, 1'b0, 1'b1, 4, 0);
        run_cmp("lt_top", 64'hBBAB_173D_F27A_C81E, 64'hFE7D_2BA2_32A8_82AA, 1'b0, 1'b1, 1'b0, 1, 0);
        run_cmp("gt_top", 64'hDDFE_D8D9_992D_A8C2, 64'hCC72_DF99_B7B1_BBAC, 1'b1, 1'b0, 1'b0, 1, 0);
        run_cmp("gt_lsb", 64'h0000_0000_0000_0001, 64'h0, 1'b1, 1'b0, 1'b0, 4, 0);
        run_cmp("gt_s2", 64'h1234_5678_0000_0000, 64'h1234_5677_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 2, 0);
        run_cmp("gt_s3", 64'h0000_0000_0001_0000, 64'h0, 1'b1, 1'b0, 1'b0, 3, 0);
        run_cmp("lt_s4", 64'h0, 64'h0000_0000_0000_0001, 1'b0, 1'b1, 1'b0, 4, 0);
        run_cmp("eq_ones", 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 4, 0);
        run_cmp("stall_lt", 64'h0000_1111_0000_0000, 64'h0000_1111_0000_0001, 1'b0, 1'b1, 1'b0, 4, 10);
        // Lower-slice MSB stays unsigned in both builds.
        run_cmp("low_msb", 64'h0000_0000_0000_8000, 64'h0, 1'b1, 1'b0, 1'b0, 4, 0);

`ifdef COMPARATOR_64BIT_SEQ_SIGNED_EN
        run_cmp("sgn_min", 64'h8000_0000_0000_0000, 64'h0, 1'b0, 1'b1, 1'b0, 1, 0);
        run_cmp("sgn_m1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 1'b0, 1, 0);
`else
        run_cmp("sgn_min", 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b0, 1'b0, 1, 0);
        run_cmp("sgn_m1", 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b1, 1'b0, 1'b0, 1, 0);
`endif

        // Abort an equal-operand compare on its second CMP edge.
        ifc.a        = 64'h0;
        ifc.b        = 64'h0;
        ifc.in_valid = 1'b1;
        tick();
        ifc.in_valid = 1'b0;
        tick();
        check("abort_no_early", 64'(ifc.out_valid), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("abort_in_ready", 64'(ifc.in_ready), 64'd1);
        check("abort_out_valid", 64'(ifc.out_valid), 64'd0);
        check("abort_flags", 64'({ifc.greater, ifc.less, ifc.equal}), 64'd0);
        check("abort_cmp_cycles", 64'(ifc.cmp_cycles), 64'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("abort_quiet", 64'(ifc.out_valid), 64'd0);
        end
        run_cmp("post_abort", 64'h0000_0000_ABCD_0000, 64'h0000_0000_ABCE_0000, 1'b0, 1'b1, 1'b0, 3, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_errors);
        $finish;
    end
endmodule
